// File: rtl/shift_out_sequencer_if.sv
// shift_out_sequencer_if: valid/ready word handshake between producer and transmitter
interface shift_out_sequencer_if #(parameter int Width = 8);
  logic             valid;
  logic             ready;
  logic [Width-1:0] data;
  modport master (output valid, output data, input ready);
  modport slave (input valid, input data, output ready);
endinterface

// File: rtl/shift_out_sequencer.sv
// shift_out_sequencer: SPI-style frame controller driving a load/shift register with sclk and cs_n
module shift_out_sequencer #(
  parameter int Width    = 8,
  parameter int DivWidth = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DivWidth-1:0] div,
  shift_out_sequencer_if.slave tx,
  output logic                sr_load,
  output logic                sr_enable,
  output logic [Width-1:0]    sr_data,
  output logic                sclk,
  output logic                cs_n,
  output logic                busy,
  output logic                done
);
  localparam int BW = Width > 1 ? $clog2(Width) : 1;
  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD} state_t;
  state_t              state;
  logic [DivWidth-1:0] div_q, cnt;
  logic [BW-1:0]       bit_cnt;
  logic                accept, phase_end;
  assign tx.ready  = state == IDLE;
  assign accept    = tx.valid & tx.ready;
  assign sr_load   = accept;
  assign sr_data   = tx.data;
  assign busy      = state != IDLE;
  assign phase_end = cnt == div_q;
  // Phase sequencer: every non-idle state lasts div+1 cycles; outputs change with the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      div_q     <= '0;
      cnt       <= '0;
      bit_cnt   <= '0;
      sclk      <= 1'b0;
      cs_n      <= 1'b1;
      sr_enable <= 1'b0;
      done      <= 1'b0;
    end else begin
      sr_enable <= 1'b0;
      done      <= 1'b0;
      cnt       <= (state == IDLE || phase_end) ? '0 : cnt + 1'b1;
      case (state)
        IDLE: if (accept) begin
          state   <= SETUP;
          div_q   <= div;
          bit_cnt <= '0;
          cs_n    <= 1'b0;
        end
        SETUP: if (phase_end) begin
          state <= HIGH;
          sclk  <= 1'b1;
        end
        HIGH: if (phase_end) begin
          sclk      <= 1'b0;
          sr_enable <= 1'b1;
          bit_cnt   <= bit_cnt + 1'b1;
          state     <= bit_cnt == BW'(Width - 1) ? HOLD : LOW;
        end
        LOW: if (phase_end) begin
          state <= HIGH;
          sclk  <= 1'b1;
        end
        HOLD: if (phase_end) begin
          state <= IDLE;
          cs_n  <= 1'b1;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_out_sequencer.sv
// tb_shift_out_sequencer: randomized bench against a cycle-offset frame model plus an attached shift register
module tb_shift_out_sequencer;
  localparam int W = 8;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   div = '0;
  logic         sr_load, sr_enable, sclk, cs_n, busy, done;
  logic [W-1:0] sr_data;
  logic [W-1:0] sreg;
  int           n_cmp = 0;
  int           n_err = 0;
  int           t = 0;
  int           p = 1;
  logic [W-1:0] word = '0;
  int           ph;
  logic         b;
  shift_out_sequencer_if #(.Width(W)) tx ();
  shift_out_sequencer #(.Width(W), .DivWidth(8)) dut (
    .clk(clk), .rst_n(rst_n), .div(div), .tx(tx.slave),
    .sr_load(sr_load), .sr_enable(sr_enable), .sr_data(sr_data),
    .sclk(sclk), .cs_n(cs_n), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  function automatic int nf();
    return (2 * W + 1) * p;
  endfunction
  function automatic logic m_busy();
    return t >= 1 && t <= nf();
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  // Attached parallel-load / LSB-first shift register fed by the DUT strobes
  always @(posedge clk)
    if (sr_load) sreg <= sr_data;
    else if (sr_enable) sreg <= sreg >> 1;
  // Frame model: t is the cycle offset since accept, 0 when idle, nf()+1 in the done cycle
  always @(posedge clk or negedge rst_n)
    if (!rst_n) t <= 0;
    else if (!m_busy() && tx.valid) begin
      t    <= 1;
      p    <= int'(div) + 1;
      word <= tx.data;
    end else t <= m_busy() ? t + 1 : 0;
  // Compare every output mid-cycle against the model's view of the frame
  always @(negedge clk) begin
    b  = m_busy();
    ph = b ? (t - 1) / p : 0;
    check("tx_ready", tx.ready, !b);
    check("sr_load", sr_load, tx.valid && !b);
    check("sr_data", sr_data, tx.data);
    check("busy", busy, b);
    check("cs_n", cs_n, !b);
    check("sclk", sclk, b && ph % 2 == 1);
    check("sr_enable", sr_enable, b && ph >= 2 && ph % 2 == 0 && (t - 1) % p == 0);
    check("done", done, rst_n && t == nf() + 1);
    if (b && ph % 2 == 1 && (t - 1) % p == 0) check("serial_bit", sreg[0], word[(ph - 1) / 2]);
  end
  task automatic wait_accept();
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      if (t == 1) return;
    end
    check("accept_timeout", 0, 1);
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      if (!m_busy()) return;
    end
    check("idle_timeout", 0, 1);
  endtask
  initial begin
    tx.valid = 1'b1;
    tx.data  = 8'hA5;
    div      = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", tx.ready, 1);
    check("rst_cs_n", cs_n, 1);
    check("rst_sr_load", sr_load, 1);
    rst_n = 1'b1;
    wait_accept();
    tx.valid = 1'b0;
    wait_idle();
    div      = 8'd3;
    tx.data  = 8'h01;
    tx.valid = 1'b1;
    wait_accept();
    tx.valid = 1'b0;
    div      = 8'd0;
    repeat (20) @(posedge clk);
    #1;
    tx.valid = 1'b1;
    tx.data  = 8'h3C;
    wait_accept();
    check("bp_word", word, 8'h3C);
    tx.valid = 1'b0;
    wait_idle();
    tx.data  = 8'hFF;
    tx.valid = 1'b1;
    wait_accept();
    tx.data = 8'h00;
    wait_accept();
    tx.valid = 1'b0;
    wait_idle();
    div      = 8'd1;
    tx.data  = W'($urandom);
    tx.valid = 1'b1;
    wait_accept();
    tx.valid = 1'b0;
    for (int i = 0; i < 100 && t != 12; i++) begin
      @(posedge clk);
      #1;
    end
    check("reset_point", t, 12);
    rst_n = 1'b0;
    #1;
    check("async_cs_n", cs_n, 1);
    check("async_sclk", sclk, 0);
    check("async_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      tx.valid = $urandom_range(0, 2) == 0;
      tx.data  = W'($urandom);
      div      = 8'($urandom_range(0, 3));
      @(posedge clk);
      #1;
    end
    tx.valid = 1'b0;
    wait_idle();
    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
